z16_data_memory_pipe: RTL
=========================

Name: z16_data_memory_pipe

Overview:
- Parametrised successor to the Z16 single-port data memory.
- Adds configurable width, depth and read latency, byte-enable writes, and a request/valid handshake.
- Adds alignment and range error reporting, plus a hardware zero-fill after reset.
- Sits between the Z16 load/store stage and the data array; the LSU stalls on o_ready.

Parameters:
- DATA_W, 16, data word width in bits; multiple of 8.
- ADDR_W, 16, byte-address width.
- DEPTH, 256, number of DATA_W-bit words; power of 2.
- READ_LAT, 1, cycles from accepted read to o_valid; legal values 1 or 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  access request.
- i_we  in  1  1 = write, 0 = read; sampled with i_req.
- i_addr  in  ADDR_W  byte address.
- i_be  in  DATA_W/8  byte enables; bit k maps to data[8k+7:8k] (little-endian).
- i_data  in  DATA_W  write data.
- o_ready  out  1  block accepts requests.
- o_valid  out  1  read data valid (1-cycle pulse).
- o_data  out  DATA_W  read data.
- o_err  out  1  access fault (1-cycle pulse).

Behaviour:
- Reset (async assert) forces all outputs and control to zero and enters INIT:
  - o_ready=0, o_valid=0, o_err=0, o_data=0.
  - Read pipeline cleared; FSM=INIT with clear index 0.
- Array contents are not reset directly; INIT zero-fills them.
- INIT state:
  - Writes 0 to word[idx] each cycle, idx = 0..DEPTH-1.
  - After writing DEPTH-1, goes to RUN; o_ready=1 from the next cycle.
  - INIT lasts exactly DEPTH cycles after reset release.
  - Requests during INIT are ignored, with no valid/err response.
- RUN state: o_ready stays 1; one access is accepted per cycle when i_req=1.
- Word index = i_addr >> log2(DATA_W/8).
- Fault conditions:
  - Misaligned: any of the low log2(DATA_W/8) address bits nonzero.
  - Out of range: word index >= DEPTH.
- Faulting access:
  - Array unchanged.
  - o_err=1 for one cycle, READ_LAT cycles after acceptance, for both reads and writes.
  - o_valid=0 in that cycle; o_data holds its previous value.
- Write:
  - Only bytes with i_be[k]=1 update, at the accepting edge.
  - No o_valid is produced.
  - i_be=0 is a legal no-op with no error.
- Read:
  - Array is read at the accepting edge.
  - o_data and o_valid appear READ_LAT cycles later; i_be is ignored.
  - o_data holds the last read value until the next valid read.
- Ordering:
  - A read accepted the cycle after a write to the same word returns the new data.
  - A write in the cycle after a read does not affect that read, even when READ_LAT=2.
- Pipeline: back-to-back reads give back-to-back o_valid pulses, in order.
- Reset mid-operation:
  - In-flight reads are dropped; no valid/err is emitted.
  - INIT restarts from index 0, so prior contents become 0.

Test Plan:
- Defaults, release reset:
  - o_ready=0 for exactly 256 cycles, then 1.
  - Read 0x0100 -> o_valid 1 cycle later, o_data=0x0000.
- Write 0x0100 = 0x5555, i_be=2'b11; read 0x0100 next cycle -> o_valid, o_data=0x5555.
- Write 0x0100 = 0xAAFF, i_be=2'b01; read 0x0100 -> o_data=0x55FF.
- Fault cases:
  - Read 0x0101 -> o_err=1, o_valid=0, o_data unchanged.
  - Write 0x0200 = 0x1234 -> o_err=1.
  - Then read 0x0000 -> 0x0000.
- READ_LAT=2: reads 0x0100, 0x0102, 0x0000 on consecutive cycles -> o_valid on cycles +2, +3, +4 with data in request order.
- Write 0x0100 = 0x5555, then assert i_rst_n=0 mid-read:
  - Outputs go to 0 immediately.
  - After release and INIT, read 0x0100 -> 0x0000.

Source files
------------

// File: rtl/z16_data_memory_pipe.sv
// z16_data_memory_pipe
// Single-port data memory for the Z16 load/store stage with a request/valid
// handshake, byte-enable writes, a 1- or 2-cycle read pipeline, alignment and
// range fault reporting, and a hardware zero-fill of the array after reset.
module z16_data_memory_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_data,
  output logic                o_ready,
  output logic                o_valid,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = $clog2(DEPTH);
  // Any READ_LAT other than 2 is treated as 1.
  localparam int LAT   = (READ_LAT == 2) ? 2 : 1;

  // Byte-offset bits inside a word: nonzero means misaligned.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  // Address bits above the word index: nonzero means word index >= DEPTH.
  localparam logic [ADDR_W-1:0] HI_MASK  = ~ADDR_W'((64'd1 << (OFF_W + IDX_W)) - 64'd1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_n;
  logic [IDX_W-1:0]   init_idx_r;
  logic [IDX_W-1:0]   init_idx_n;
  logic               init_we_s;
  logic               ready_r;

  logic [DATA_W-1:0]  mem_r [DEPTH];

  logic               accept_s;
  logic               misalign_s;
  logic               range_s;
  logic               fault_s;
  logic               rd_ok_s;
  logic               wr_ok_s;
  logic               err_acc_s;
  logic [IDX_W-1:0]   word_idx_s;

  // Stage LAT-1 of the read pipeline drives the outputs directly.
  logic [LAT-1:0]     vld_r;
  logic [LAT-1:0]     err_r;
  logic [DATA_W-1:0]  dat_r [LAT];

  // Decode the incoming request into accept, fault and word index.
  always_comb begin
    accept_s   = 1'b0;
    misalign_s = 1'b0;
    range_s    = 1'b0;
    fault_s    = 1'b0;
    rd_ok_s    = 1'b0;
    wr_ok_s    = 1'b0;
    err_acc_s  = 1'b0;
    word_idx_s = i_addr[OFF_W +: IDX_W];
    accept_s   = i_req & ready_r;
    misalign_s = |(i_addr & OFF_MASK);
    range_s    = |(i_addr & HI_MASK);
    fault_s    = misalign_s | range_s;
    if (accept_s) begin
      err_acc_s = fault_s;
      rd_ok_s   = ~fault_s & ~i_we;
      wr_ok_s   = ~fault_s &  i_we;
    end else begin
      err_acc_s = 1'b0;
      rd_ok_s   = 1'b0;
      wr_ok_s   = 1'b0;
    end
  end

  // Next-state logic: INIT walks the clear index over every word, then RUN.
  always_comb begin
    state_n    = state_r;
    init_idx_n = init_idx_r;
    init_we_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        init_we_s = 1'b1;
        if (init_idx_r == LAST_IDX) begin
          state_n    = ST_RUN;
          init_idx_n = {IDX_W{1'b0}};
        end else begin
          state_n    = ST_INIT;
          init_idx_n = init_idx_r + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_n    = ST_RUN;
        init_idx_n = {IDX_W{1'b0}};
      end
      default: begin
        state_n    = ST_INIT;
        init_idx_n = {IDX_W{1'b0}};
      end
    endcase
  end

  // State register; ready rises together with the move into RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_INIT;
      init_idx_r <= {IDX_W{1'b0}};
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      init_idx_r <= init_idx_n;
      ready_r    <= (state_n == ST_RUN);
    end
  end

  // Array write port: zero-fill during INIT, byte-enabled stores in RUN.
  always_ff @(posedge i_clk) begin
    if (init_we_s) begin
      mem_r[init_idx_r] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      for (int k = 0; k < BE_W; k++) begin
        if (i_be[k]) begin
          mem_r[word_idx_s][8*k +: 8] <= i_data[8*k +: 8];
        end
      end
    end
  end

  // Read/err pipeline; data stages only load on a valid read so o_data holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_r <= {LAT{1'b0}};
      err_r <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        dat_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      vld_r[0] <= rd_ok_s;
      err_r[0] <= err_acc_s;
      if (rd_ok_s) begin
        dat_r[0] <= mem_r[word_idx_s];
      end
      for (int i = 1; i < LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        err_r[i] <= err_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign o_ready = ready_r;
  assign o_valid = vld_r[LAT-1];
  assign o_err   = err_r[LAT-1];
  assign o_data  = dat_r[LAT-1];

endmodule
